// File: rtl/latch_scm_ctrl.sv
// latch_scm_ctrl: req/gnt front end for the latch-based SCM; partial-word writes become a 2-cycle read-modify-write.
// Optional feature macro: LATCH_SCM_CTRL_WRITE_RESP_EN (every granted write also returns an rdata=0 response).

module latch_scm_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    localparam int BE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  scm_re_o,
    output logic [ADDR_WIDTH-1:0] scm_raddr_o,
    input  logic [DATA_WIDTH-1:0] scm_rdata_i,
    output logic                  scm_we_o,
    output logic [ADDR_WIDTH-1:0] scm_waddr_o,
    output logic [DATA_WIDTH-1:0] scm_wdata_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

    // Byte-wise merge of new write data over the word just read from the memory.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] res;
        for (int b = 0; b < BE_WIDTH; b++) begin
            res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

    state_e                state_r;
    state_e                state_nxt_s;
    logic                  gnt_s;
    logic                  rd_gnt_s;
    logic                  full_wr_s;
    logic                  part_wr_s;
    logic                  wr_resp_s;
    logic                  scm_re_s;
    logic                  scm_we_s;
    logic [ADDR_WIDTH-1:0] scm_raddr_s;
    logic [ADDR_WIDTH-1:0] scm_waddr_s;
    logic [DATA_WIDTH-1:0] scm_wdata_s;
    logic [ADDR_WIDTH-1:0] held_addr_r;
    logic [DATA_WIDTH-1:0] held_wdata_r;
    logic [BE_WIDTH-1:0]   held_be_r;
    logic [ADDR_WIDTH-1:0] last_raddr_r;
    logic [ADDR_WIDTH-1:0] last_waddr_r;
    logic [DATA_WIDTH-1:0] last_wdata_r;
    logic                  rd_pend_r;
    logic                  rvalid_r;

    assign gnt_s     = req_i & (state_r == IDLE);
    assign rd_gnt_s  = gnt_s & ~we_i;
    assign full_wr_s = gnt_s & we_i & (&be_i);
    assign part_wr_s = gnt_s & we_i & ~(&be_i) & (|be_i);

`ifdef LATCH_SCM_CTRL_WRITE_RESP_EN
    logic zero_wr_s;
    assign zero_wr_s = gnt_s & we_i & ~(|be_i);
    // Partial writes answer after their MERGE cycle, other writes one cycle after grant.
    assign wr_resp_s = full_wr_s | zero_wr_s | (state_r == MERGE);
`else
    assign wr_resp_s = 1'b0;
`endif

    // State register; reset drops any pending merge write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (part_wr_s) begin
                    state_nxt_s = MERGE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MERGE:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Memory port drive; idle ports replay the last issued address/data.
    always_comb begin
        scm_re_s    = 1'b0;
        scm_we_s    = 1'b0;
        scm_raddr_s = last_raddr_r;
        scm_waddr_s = last_waddr_r;
        scm_wdata_s = last_wdata_r;
        case (state_r)
            IDLE: begin
                if (rd_gnt_s || part_wr_s) begin
                    scm_re_s    = 1'b1;
                    scm_raddr_s = addr_i;
                end else begin
                    scm_re_s = 1'b0;
                end
                if (full_wr_s) begin
                    scm_we_s    = 1'b1;
                    scm_waddr_s = addr_i;
                    scm_wdata_s = wdata_i;
                end else begin
                    scm_we_s = 1'b0;
                end
            end
            MERGE: begin
                scm_we_s    = 1'b1;
                scm_waddr_s = held_addr_r;
                scm_wdata_s = merge_bytes(scm_rdata_i, held_wdata_r, held_be_r);
            end
            default: begin
                scm_re_s = 1'b0;
                scm_we_s = 1'b0;
            end
        endcase
    end

    // Capture of the partial write and of the last driven memory port values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            held_addr_r  <= {ADDR_WIDTH{1'b0}};
            held_wdata_r <= {DATA_WIDTH{1'b0}};
            held_be_r    <= {BE_WIDTH{1'b0}};
            last_raddr_r <= {ADDR_WIDTH{1'b0}};
            last_waddr_r <= {ADDR_WIDTH{1'b0}};
            last_wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (part_wr_s) begin
                held_addr_r  <= addr_i;
                held_wdata_r <= wdata_i;
                held_be_r    <= be_i;
            end
            if (scm_re_s) begin
                last_raddr_r <= scm_raddr_s;
            end
            if (scm_we_s) begin
                last_waddr_r <= scm_waddr_s;
                last_wdata_r <= scm_wdata_s;
            end
        end
    end

    // Response tracking: rd_pend_r tells read data apart from write acknowledges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend_r <= 1'b0;
            rvalid_r  <= 1'b0;
        end else begin
            rd_pend_r <= rd_gnt_s;
            rvalid_r  <= rd_gnt_s | wr_resp_s;
        end
    end

    assign gnt_o       = gnt_s;
    assign rvalid_o    = rvalid_r;
    assign rdata_o     = rd_pend_r ? scm_rdata_i : {DATA_WIDTH{1'b0}};
    assign scm_re_o    = scm_re_s;
    assign scm_raddr_o = scm_raddr_s;
    assign scm_we_o    = scm_we_s;
    assign scm_waddr_o = scm_waddr_s;
    assign scm_wdata_o = scm_wdata_s;

endmodule

// File: doc/latch_scm_ctrl.md
# latch_scm_ctrl

Request-side controller placed directly upstream of the latch-based standard-cell memory. It converts a single-port req/gnt/rvalid interface with byte enables into the memory's separate read-enable and write-enable ports. It executes partial-word writes as a two-cycle read-modify-write, because the memory stores whole words only. It returns read responses one cycle after grant.

## Interface
- `ADDR_WIDTH`, default 5: word-address width; the memory holds 2**ADDR_WIDTH words.
- `DATA_WIDTH`, default 32: word width; must be a multiple of 8.
- `BE_WIDTH`, derived as DATA_WIDTH/8: byte-enable width; not overridable.
- `clk_i`  in  1  clock; the same clock that drives the memory.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  request accepted this cycle.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  ADDR_WIDTH  word address.
- `wdata_i`  in  DATA_WIDTH  write data.
- `be_i`  in  BE_WIDTH  byte enables; ignored on reads.
- `rvalid_o`  out  1  response valid.
- `rdata_o`  out  DATA_WIDTH  response data.
- `scm_re_o`  out  1  memory ReadEnable.
- `scm_raddr_o`  out  ADDR_WIDTH  memory ReadAddr.
- `scm_rdata_i`  in  DATA_WIDTH  memory ReadData; valid the cycle after `scm_re_o`.
- `scm_we_o`  out  1  memory WriteEnable.
- `scm_waddr_o`  out  ADDR_WIDTH  memory WriteAddr.
- `scm_wdata_o`  out  DATA_WIDTH  memory WriteData.

## Operation
- FSM states: IDLE and MERGE. Reset state is IDLE.
- `gnt_o` = `req_i` & (state == IDLE). It is combinational, and there is no request backpressure beyond it.
- Read granted:
  - `scm_re_o`=1, `scm_raddr_o`=`addr_i`.
  - Pending-read flag registered.
- Full write granted (`be_i` all ones):
  - `scm_we_o`=1, `scm_waddr_o`=`addr_i`, `scm_wdata_o`=`wdata_i`.
  - State stays IDLE.
- Partial write granted (`be_i` neither all ones nor zero), cycle N:
  - `scm_re_o`=1 with `addr_i`.
  - Register addr, wdata and be; go to MERGE.
- MERGE, cycle N+1:
  - `gnt_o`=0, `scm_we_o`=1, `scm_waddr_o`=held address.
  - For each byte b, `scm_wdata_o`[b] = held be[b] ? held wdata[b] : `scm_rdata_i`[b].
  - Return to IDLE.
- Zero-byte write (`be_i`=0): granted, no memory access, no state change.
- When no access is issued, `scm_re_o`/`scm_we_o` are 0, and address/data outputs hold their last value (don't-care).
- `rdata_o` = `scm_rdata_i` when `rvalid_o` marks a read response, else 0.
- The response channel cannot backpressure, and responses never collide: at most one response is produced per cycle.

## Timing
- Read latency: grant in cycle N, `rvalid_o`=1 in N+1 with data.
- Full-write throughput: one per cycle.
- Partial write: occupies 2 cycles; the next grant is possible in N+2.
- Read-after-write, same address, granted in consecutive cycles: returns the new data. The memory updates during the cycle after the write grant, and the read address is sampled at the following edge.
- Back-to-back reads: one per cycle, responses in order.
- Reset asserted mid-RMW: FSM goes to IDLE immediately. The pending write is dropped (no `scm_we_o`) and memory contents are unchanged by the controller.
- Reset values: state IDLE; `rvalid_o`=0; `rdata_o`=0; pending-read flag 0.

## Configuration
- Macro: `LATCH_SCM_CTRL_WRITE_RESP_EN`.
- Defined: every granted write also produces `rvalid_o`=1 with `rdata_o`=0:
  - full and zero-byte writes: in cycle N+1;
  - partial writes: in N+2, after the MERGE cycle.
- Not defined: `rvalid_o` is asserted for reads only, and writes are fire-and-forget.

## Test plan
- Reset, then write 0xDEADBEEF to addr 3 with be=0xF, then read addr 3 -> `gnt_o`=1 in both cycles; `rvalid_o` one cycle after the read grant with `rdata_o`=0xDEADBEEF.
- Addr 5 holds 0x11223344; partial write of 0xAABBCCDD with be=0x5, then read addr 5:
  - `gnt_o` drops for one cycle;
  - `scm_we_o` is high in the MERGE cycle with data 0x11BB33DD;
  - the read returns 0x11BB33DD.
- Continuous reads of addresses 0..31 -> one grant per cycle; 32 in-order responses, each one cycle after its grant.
- Assert `rst_ni`=0 during MERGE of a partial write to addr 7 -> no `scm_we_o` pulse; after reset, a read of addr 7 returns the pre-write value; `rvalid_o`=0 throughout reset.
- Write with be=0 to addr 2 -> granted; no `scm_re_o`/`scm_we_o`; addr 2 is unchanged.
- With `LATCH_SCM_CTRL_WRITE_RESP_EN`: full write in cycle N -> `rvalid_o` in N+1 with `rdata_o`=0; partial write -> `rvalid_o` in N+2. Without the macro, neither write produces `rvalid_o`.
